// File: rtl/cmp_iter.sv
// Iterative branch/compare unit: scans two operands MSB-first,
// CHUNK bits per cycle, exits early on the first differing chunk.
module cmp_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             c,
  output logic             eq,
  output logic             lt
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MSB_M = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_n;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_ctrl;
  logic             r_c;
  logic             r_eq;
  logic             r_lt;

  logic             w_accept;
  logic             w_signed;
  logic [WIDTH-1:0] w_flip;
  logic [CW-1:0]    w_sel;
  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic             w_diff;
  logic             w_last;
  logic             w_fin;
  logic             w_eq_n;
  logic             w_lt_n;
  logic             w_c_n;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign c  = r_c;
  assign eq = r_eq;
  assign lt = r_lt;

  assign w_accept = in_ready && in_valid;
  // Signed compare: flipping both sign bits maps it onto unsigned order
  assign w_signed = (ctrl[2:1] == 2'b10);
  assign w_flip   = w_signed ? MSB_M : '0;

  assign w_sel  = LAST - r_cnt;
  assign w_diff = (w_ca != w_cb);
  assign w_last = (r_cnt == LAST);
  assign w_fin  = (r_state == S_SCAN) && (w_diff || w_last);
  assign w_eq_n = ~w_diff;
  assign w_lt_n = w_diff && (w_ca < w_cb);

  // Select the chunk under scan, counting down from the MSB end
  always_comb begin
    w_ca = '0;
    w_cb = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (w_sel == CW'(i)) begin
        w_ca = r_a[i*CHUNK +: CHUNK];
        w_cb = r_b[i*CHUNK +: CHUNK];
      end
    end
  end

  // Map the scan outcome onto the requested branch condition
  always_comb begin
    w_c_n = 1'b0;
    case (r_ctrl)
      3'b000:  w_c_n = w_eq_n;
      3'b001:  w_c_n = ~w_eq_n;
      3'b100:  w_c_n = w_lt_n;
      3'b101:  w_c_n = ~w_lt_n;
      3'b110:  w_c_n = w_lt_n;
      3'b111:  w_c_n = ~w_lt_n;
      default: w_c_n = 1'b0;
    endcase
  end

  // Next-state logic for the IDLE/SCAN/DONE sequence
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_n = S_SCAN;
      S_SCAN:  if (w_fin) w_state_n = S_DONE;
      S_DONE:  if (out_ready) w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  // Operand capture, scan counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_ctrl <= '0;
      r_c    <= 1'b0;
      r_eq   <= 1'b0;
      r_lt   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a    <= a ^ w_flip;
        r_b    <= b ^ w_flip;
        r_ctrl <= ctrl;
        r_cnt  <= '0;
      end
      if (r_state == S_SCAN) begin
        if (w_fin) begin
          r_c  <= w_c_n;
          r_eq <= w_eq_n;
          r_lt <= w_lt_n;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cmp_iter.sv
// Directed bench for cmp_iter: a CHUNK=8 and a CHUNK=32
// instance, table vectors plus stall and reset sequences.
module tb_cmp_iter;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  ctrl;
  logic        iv0, iv1, or0, or1;
  logic        ir0, ir1, ov0, ov1;
  logic        c0, c1, eq0, eq1, lt0, lt1;

  int n_chk;
  int n_err;

  cmp_iter #(.WIDTH(32), .CHUNK(8)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0),
    .a(a), .b(b), .ctrl(ctrl), .out_valid(ov0),
    .out_ready(or0), .c(c0), .eq(eq0), .lt(lt0)
  );

  cmp_iter #(.WIDTH(32), .CHUNK(32)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
    .a(a), .b(b), .ctrl(ctrl), .out_valid(ov1),
    .out_ready(or1), .c(c1), .eq(eq1), .lt(lt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    logic        c;
    logic        eq;
    logic        lt;
    int          lat;
  } vec_t;

  vec_t vt[14];

  // {in_ready, out_valid, c, eq, lt}
  function automatic logic [4:0] obs(input logic sel);
    if (sel) return {ir1, ov1, c1, eq1, lt1};
    return {ir0, ov0, c0, eq0, lt0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic accept(input logic sel, input logic [31:0] va,
                        input logic [31:0] vb, input logic [2:0] vc);
    logic [4:0] o;
    @(negedge clk);
    a = va;
    b = vb;
    ctrl = vc;
    if (sel) iv1 = 1'b1;
    else     iv0 = 1'b1;
    o = obs(sel);
    chk("accept_ready", 32'(o[4]), 32'd1);
    @(posedge clk);
    #1;
    iv0 = 1'b0;
    iv1 = 1'b0;
  endtask

  task automatic wait_valid(input logic sel, output int lat);
    logic [4:0] o;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      o = obs(sel);
      if (o[3]) break;
    end
  endtask

  task automatic retire(input logic sel);
    @(negedge clk);
    if (sel) or1 = 1'b1;
    else     or0 = 1'b1;
    @(posedge clk);
    #1;
    or0 = 1'b0;
    or1 = 1'b0;
    @(negedge clk);
    chk("retire_state", 32'(obs(sel)[4:3]), 32'b10);
  endtask

  initial begin
    int         lat;
    logic [4:0] o;
    n_chk = 0;
    n_err = 0;
    rst  = 1'b1;
    a    = '0;
    b    = '0;
    ctrl = '0;
    iv0  = 1'b0;
    iv1  = 1'b0;
    or0  = 1'b0;
    or1  = 1'b0;

    vt[0]  = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 3'b100, 1, 0, 1, 1};
    vt[1]  = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 3'b110, 0, 0, 0, 1};
    vt[2]  = '{1'b0, 32'h12345678, 32'h12345678, 3'b000, 1, 1, 0, 4};
    vt[3]  = '{1'b0, 32'h12345678, 32'h12345678, 3'b001, 0, 1, 0, 4};
    vt[4]  = '{1'b0, 32'h00000001, 32'h00000002, 3'b110, 1, 0, 1, 4};
    vt[5]  = '{1'b0, 32'h00000001, 32'h00000002, 3'b111, 0, 0, 1, 4};
    vt[6]  = '{1'b0, 32'h00000001, 32'h00000002, 3'b011, 0, 0, 1, 4};
    vt[7]  = '{1'b0, 32'h00010000, 32'h00020000, 3'b100, 1, 0, 1, 2};
    vt[8]  = '{1'b0, 32'h80000000, 32'h7FFFFFFF, 3'b101, 0, 0, 1, 1};
    vt[9]  = '{1'b0, 32'h80000000, 32'h7FFFFFFF, 3'b010, 0, 0, 0, 1};
    vt[10] = '{1'b0, 32'h00000012, 32'h00000013, 3'b000, 0, 0, 1, 4};
    vt[11] = '{1'b1, 32'h80000000, 32'h7FFFFFFF, 3'b100, 1, 0, 1, 1};
    vt[12] = '{1'b1, 32'h80000000, 32'h7FFFFFFF, 3'b110, 0, 0, 0, 1};
    vt[13] = '{1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 3'b000, 1, 1, 0, 1};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_u0", 32'(obs(1'b0)), 32'b10000);
    chk("reset_u1", 32'(obs(1'b1)), 32'b10000);

    for (int i = 0; i < 14; i++) begin
      accept(vt[i].sel, vt[i].a, vt[i].b, vt[i].ctrl);
      wait_valid(vt[i].sel, lat);
      o = obs(vt[i].sel);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("v%0d_c", i), 32'(o[2]), 32'(vt[i].c));
      chk($sformatf("v%0d_eq", i), 32'(o[1]), 32'(vt[i].eq));
      chk($sformatf("v%0d_lt", i), 32'(o[0]), 32'(vt[i].lt));
      chk($sformatf("v%0d_busy", i), 32'(o[4]), 32'd0);
      retire(vt[i].sel);
    end

    // Stall in DONE with junk on the request side
    accept(1'b0, 32'h12345678, 32'h12345678, 3'b000);
    wait_valid(1'b0, lat);
    chk("stall_lat", 32'(lat), 32'd4);
    a    = 32'h00000000;
    b    = 32'hFFFFFFFF;
    ctrl = 3'b110;
    iv0  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("stall_%0d", i), 32'(obs(1'b0)), 32'b01110);
    end
    iv0 = 1'b0;
    retire(1'b0);
    @(negedge clk);
    chk("idle_hold", 32'(obs(1'b0)), 32'b10110);

    // Reset while scanning with cnt==2
    accept(1'b0, 32'hAAAAAAAA, 32'hAAAAAAAA, 3'b000);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_scan", 32'(obs(1'b0)), 32'b00110);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_abort", 32'(obs(1'b0)), 32'b10000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("no_result_%0d", i), 32'(obs(1'b0)), 32'b10000);
    end
    accept(1'b0, 32'h00000001, 32'h00000002, 3'b110);
    wait_valid(1'b0, lat);
    chk("post_rst_lat", 32'(lat), 32'd4);
    chk("post_rst_res", 32'(obs(1'b0)), 32'b01101);
    retire(1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
